// File: rtl/rtc_malrm_core_if.sv
// Register-side bus of the multi-alarm RTC timebase.
// master: the APB register file (drives controls, reads status).
// slave : rtc_malrm_core.
// Signals: en/pscr (prescaler), cnt_wr/cnt_wdata (counter load),
//   cmp_wr/per_wr/alrm_wdata (alarm writes), ie/ista_wr/ista_wdata (irq),
//   cnt/tick/armed/ista/irq (status back to the register file).
interface rtc_malrm_core_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int ALRM_NUM   = 4
);
  logic                  en_i;
  logic [PSCR_WIDTH-1:0] pscr_i;
  logic                  cnt_wr_i;
  logic [CNT_WIDTH-1:0]  cnt_wdata_i;
  logic [ALRM_NUM-1:0]   cmp_wr_i;
  logic [ALRM_NUM-1:0]   per_wr_i;
  logic [CNT_WIDTH-1:0]  alrm_wdata_i;
  logic [ALRM_NUM+1:0]   ie_i;
  logic                  ista_wr_i;
  logic [ALRM_NUM+1:0]   ista_wdata_i;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  tick_o;
  logic [ALRM_NUM-1:0]   armed_o;
  logic [ALRM_NUM+1:0]   ista_o;
  logic                  irq_o;

  modport master (
    output en_i, pscr_i, cnt_wr_i, cnt_wdata_i, cmp_wr_i, per_wr_i,
           alrm_wdata_i, ie_i, ista_wr_i, ista_wdata_i,
    input  cnt_o, tick_o, armed_o, ista_o, irq_o
  );
  modport slave (
    input  en_i, pscr_i, cnt_wr_i, cnt_wdata_i, cmp_wr_i, per_wr_i,
           alrm_wdata_i, ie_i, ista_wr_i, ista_wdata_i,
    output cnt_o, tick_o, armed_o, ista_o, irq_o
  );
endinterface

// File: rtl/rtc_malrm_core.sv
// Multi-channel RTC timebase: prescaled seconds counter plus ALRM_NUM alarm
// comparators, each one-shot (per==0) or periodic (cmp advances by per).
// Ports: rtc_clk_i, rtc_rst_n_i (async active-low), bus (slave modport of
//   rtc_malrm_core_if carrying all control/status signals).
// Status flags {alrm[N-1:0], ov, sec} are sticky, cleared by writing 0.
module rtc_malrm_core #(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20,
  parameter int ALRM_NUM   = 4
) (
  input  logic             rtc_clk_i,
  input  logic             rtc_rst_n_i,
  rtc_malrm_core_if.slave  bus
);
  localparam int IW = ALRM_NUM + 2;

  logic [PSCR_WIDTH-1:0] psc, lim;
  logic [CNT_WIDTH-1:0]  cnt, cnt_inc;
  logic                  tick_ev, ov_set, tick_q, irq_q;
  logic [ALRM_NUM-1:0]   match, armed;
  logic [IW-1:0]         ista, clr_mask, set_v;

  // Limits below 2 are clamped so a tick is never faster than every 3 cycles.
  assign lim     = (bus.pscr_i < PSCR_WIDTH'(2)) ? PSCR_WIDTH'(2) : bus.pscr_i;
  // A counter load in the same cycle swallows the tick and all its side effects.
  assign tick_ev = bus.en_i && !bus.cnt_wr_i && (psc >= lim);
  assign cnt_inc = cnt + CNT_WIDTH'(1);
  assign ov_set  = tick_ev && (&cnt);

  always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
    if (!rtc_rst_n_i) begin
      psc    <= '0;
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      if (!bus.en_i || bus.cnt_wr_i || tick_ev) psc <= '0;
      else                                      psc <= psc + PSCR_WIDTH'(1);
      if (bus.cnt_wr_i)  cnt <= bus.cnt_wdata_i;
      else if (tick_ev)  cnt <= cnt_inc;
      tick_q <= tick_ev;
    end
  end

  for (genvar g = 0; g < ALRM_NUM; g++) begin : g_ch
    logic [CNT_WIDTH-1:0] cmp, per;
    logic                 arm;

    // Compare against the value the counter is about to take, so the flag
    // rises on the same edge cnt reaches cmp. A cmp write masks the match.
    assign match[g] = tick_ev && arm && (cnt_inc == cmp) && !bus.cmp_wr_i[g];
    assign armed[g] = arm;

    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
      if (!rtc_rst_n_i) begin
        cmp <= '0;
        per <= '0;
        arm <= 1'b0;
      end else begin
        if (bus.cmp_wr_i[g]) begin
          cmp <= bus.alrm_wdata_i;
          arm <= 1'b1;
        end else if (match[g]) begin
          if (per == '0) arm <= 1'b0;
          else           cmp <= cmp + per;
        end
        if (bus.per_wr_i[g]) per <= bus.alrm_wdata_i;
      end
    end
  end

  assign set_v    = {match, ov_set, tick_ev};
  assign clr_mask = bus.ista_wr_i ? bus.ista_wdata_i : '1;

  // New events override a simultaneous write-0 clear.
  always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
    if (!rtc_rst_n_i) begin
      ista  <= '0;
      irq_q <= 1'b0;
    end else begin
      ista  <= (ista & clr_mask) | set_v;
      irq_q <= |(ista & bus.ie_i);
    end
  end

  assign bus.cnt_o   = cnt;
  assign bus.tick_o  = tick_q;
  assign bus.armed_o = armed;
  assign bus.ista_o  = ista;
  assign bus.irq_o   = irq_q;
endmodule
